// File: rtl/zion_basic_circuit_lib_skid_buf_if.sv
// Valid/ready handshake bundle for the skid buffer.
// Signal names are seen from the buffer: i* flow into it, o* flow out of it.
// master = the side that drives the buffer's inputs (producer/consumer pair, or bench);
// slave  = the skid buffer itself.
interface zion_basic_circuit_lib_skid_buf_if #(
    parameter int WIDTH = 8
);
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iDat;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oDat;
    logic [1:0]       oCnt;

    modport master (
        output iValid, iDat, iReady,
        input  oReady, oValid, oDat, oCnt
    );

    modport slave (
        input  iValid, iDat, iReady,
        output oReady, oValid, oDat, oCnt
    );
endinterface

// File: rtl/zion_basic_circuit_lib_skid_buf.sv
// Two-entry skid buffer: full-throughput valid/ready stage with a registered
// upstream ready. oReady is decoded only from the state flops and rst, so the
// downstream ready path never reaches the producer combinationally.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | nothing held; oValid=0, oReady=1, oCnt=0
// ST_BUSY  | main holds the head; oValid=1, oReady=1, oCnt=1
// ST_FULL  | main=head, skid=next; oValid=1, oReady=0, oCnt=2
module zion_basic_circuit_lib_skid_buf #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input logic                             clk,
    input logic                             rst,
    zion_basic_circuit_lib_skid_buf_if.slave bus
);

    if (WIDTH < 1) begin : g_bad_width
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_basic_circuit_lib_skid_buf: WIDTH must be >= 1");
`else
        $error("zion_basic_circuit_lib_skid_buf: WIDTH must be >= 1");
`endif
    end

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic             main_en;
    logic             skid_en;
    logic             ready;
    logic             valid;
    logic             push;
    logic             pop;

    assign ready = ~rst & (state_q != ST_FULL);
    assign valid = ~rst & (state_q != ST_EMPTY);
    assign push  = bus.iValid & ready;
    assign pop   = valid & bus.iReady;

    // Refill main from skid when leaving FULL, otherwise straight from upstream.
    assign main_d = (state_q == ST_FULL) ? skid_q : bus.iDat;

    assign bus.oReady = ready;
    assign bus.oValid = valid;
    assign bus.oDat   = main_q;
    assign bus.oCnt   = state_q;

    // Next state and data-register load enables.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    main_en = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (push && pop) begin
                    main_en = 1'b1;
                end else if (push) begin
                    skid_en = 1'b1;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    main_en = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State register and enable-DFF data registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= INI_DATA;
            skid_q  <= INI_DATA;
        end else begin
            state_q <= state_d;
            if (main_en) main_q <= main_d;
            if (skid_en) skid_q <= bus.iDat;
        end
    end

endmodule

// File: tb/tb_zion_basic_circuit_lib_skid_buf.sv
// Bench for the skid buffer: directed phases with hand-computed state checks,
// a scoreboard queue fed on accepted pushes and drained by a monitor on pops,
// then a random handshake soak.
module tb_zion_basic_circuit_lib_skid_buf;
    localparam int         W   = 8;
    localparam logic [7:0] INI = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zion_basic_circuit_lib_skid_buf_if #(.WIDTH(W)) bus ();

    zion_basic_circuit_lib_skid_buf #(.WIDTH(W), .INI_DATA(INI)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         cnt_model = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected data enters the scoreboard on every accepted push.
    always @(negedge clk) begin
        if (!rst && bus.iValid && bus.oReady) exp_q.push_back(bus.iDat);
    end

    // Monitor: occupancy model, flag decode, stability and in-order data.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cnt_model  = 0;
            prev_stall = 1'b0;
        end else begin
            chk("occupancy", 32'(bus.oCnt), 32'(cnt_model));
            chk("ready_flag", 32'(bus.oReady), 32'(cnt_model != 2));
            chk("valid_flag", 32'(bus.oValid), 32'(cnt_model != 0));
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.oValid), 32'd1);
                chk("stall_data", 32'(bus.oDat), 32'(prev_dat));
            end
            if (bus.oValid && bus.iReady) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL order: got %0h, expected nothing (queue empty)", bus.oDat);
                end else begin
                    chk("order", 32'(bus.oDat), 32'(exp_q.pop_front()));
                end
                cnt_model--;
            end
            if (bus.iValid && bus.oReady) cnt_model++;
            prev_stall = bus.oValid && !bus.iReady;
            prev_dat   = bus.oDat;
        end
    end

    // Drive one cycle of inputs just after the edge, then wait to mid-cycle.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rdy);
        @(posedge clk);
        #1;
        rst        = r;
        bus.iValid = v;
        bus.iDat   = d;
        bus.iReady = rdy;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [1:0] cnt, input logic vld,
                           input logic rdy, input logic [7:0] dat, input bit chk_dat);
        chk({nm, "_cnt"}, 32'(bus.oCnt), 32'(cnt));
        chk({nm, "_valid"}, 32'(bus.oValid), 32'(vld));
        chk({nm, "_ready"}, 32'(bus.oReady), 32'(rdy));
        if (chk_dat) chk({nm, "_dat"}, 32'(bus.oDat), 32'(dat));
    endtask

    initial begin
        logic r0;
        bus.iValid = 1'b0;
        bus.iDat   = '0;
        bus.iReady = 1'b0;

        // Reset then idle
        step(1, 0, 8'h00, 0);
        chk("rst_ready", 32'(bus.oReady), 32'd0);
        chk("rst_valid", 32'(bus.oValid), 32'd0);
        step(1, 1, 8'hFF, 1);
        chk("rst_ready2", 32'(bus.oReady), 32'd0);
        chk("rst_valid2", 32'(bus.oValid), 32'd0);
        step(0, 0, 8'h00, 0);
        chk_out("post_rst", 2'd0, 0, 1, INI, 1);

        // Streaming 01..10 with iReady=1
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 8'(i), 1);
            if (i == 1) chk_out("stream_first", 2'd0, 0, 1, 8'h00, 0);
            else        chk_out("stream", 2'd1, 1, 1, 8'(i - 1), 1);
        end
        step(0, 0, 8'h00, 1);
        chk_out("stream_last", 2'd1, 1, 1, 8'h10, 1);
        step(0, 0, 8'h00, 1);
        chk_out("stream_empty", 2'd0, 0, 1, 8'h00, 0);

        // Backpressure
        step(0, 1, 8'h11, 0);
        chk_out("bp0", 2'd0, 0, 1, 8'h00, 0);
        step(0, 1, 8'h22, 0);
        chk_out("bp1", 2'd1, 1, 1, 8'h11, 1);
        step(0, 1, 8'h33, 0);
        chk_out("bp_full", 2'd2, 1, 0, 8'h11, 1);
        step(0, 1, 8'h33, 0);
        chk_out("bp_hold", 2'd2, 1, 0, 8'h11, 1);
        step(0, 1, 8'h33, 1);
        chk_out("bp_rel0", 2'd2, 1, 0, 8'h11, 1);
        step(0, 1, 8'h33, 1);
        chk_out("bp_rel1", 2'd1, 1, 1, 8'h22, 1);
        step(0, 0, 8'h00, 1);
        chk_out("bp_rel2", 2'd1, 1, 1, 8'h33, 1);
        step(0, 0, 8'h00, 1);
        chk_out("bp_done", 2'd0, 0, 1, 8'h00, 0);

        // Drain from FULL
        step(0, 1, 8'h44, 0);
        step(0, 1, 8'h55, 0);
        step(0, 0, 8'h00, 1);
        chk_out("drain0", 2'd2, 1, 0, 8'h44, 1);
        step(0, 0, 8'h00, 1);
        chk_out("drain1", 2'd1, 1, 1, 8'h55, 1);
        step(0, 0, 8'h00, 1);
        chk_out("drain2", 2'd0, 0, 1, 8'h00, 0);

        // Reset while FULL
        step(0, 1, 8'h66, 0);
        step(0, 1, 8'h77, 0);
        step(0, 0, 8'h00, 0);
        chk_out("pre_rst_full", 2'd2, 1, 0, 8'h66, 1);
        step(1, 0, 8'h00, 1);
        chk("mid_rst_valid", 32'(bus.oValid), 32'd0);
        chk("mid_rst_ready", 32'(bus.oReady), 32'd0);
        step(0, 0, 8'h00, 1);
        chk_out("after_mid_rst", 2'd0, 0, 1, INI, 1);

        // Random soak, with a probe that oReady ignores iValid/iReady mid-cycle
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            rst        = 1'b0;
            bus.iValid = 1'($urandom_range(0, 1));
            bus.iDat   = 8'($urandom);
            bus.iReady = 1'($urandom_range(0, 1));
            if ((c % 8) == 0) begin
                #1;
                r0 = bus.oReady;
                bus.iReady = ~bus.iReady;
                bus.iValid = ~bus.iValid;
                #1;
                chk("ready_comb", 32'(bus.oReady), 32'(r0));
                bus.iReady = ~bus.iReady;
                bus.iValid = ~bus.iValid;
            end
        end
        for (int k = 0; k < 3; k++) step(0, 0, 8'h00, 1);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        chk("final_cnt", 32'(bus.oCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/zion_basic_circuit_lib_skid_buf.md
Name: zion_basic_circuit_lib_skid_buf

Overview:
- Two-entry valid/ready pipeline register (skid buffer) with full throughput and a registered upstream ready.
- Sits between a producer and a consumer stage. It generates the load enables for its main and skid data registers, which are enable-DFFs with synchronous reset.
- It breaks the combinational ready path while sustaining one transfer per cycle.

Parameters:
- WIDTH, 8, data width of iDat and oDat. Must be >= 1; otherwise $error at elaboration, and $finish if CHECK_ERR_EXIT is defined.
- INI_DATA, '0, reset value loaded into the main and skid data registers.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active high.
- iValid  input  1  upstream data valid.
- oReady  output  1  ready to upstream. Registered: decoded only from state flops and rst.
- iDat  input  WIDTH  upstream data.
- oValid  output  1  downstream data valid.
- iReady  input  1  downstream ready.
- oDat  output  WIDTH  downstream data, driven directly from the main register.
- oCnt  output  2  occupancy, 0..2.

Behaviour:
- One clock, clk. rst is synchronous, active high, sampled on the rising clk edge.
- Handshake definitions:
  - Upstream transfer (push) = iValid & oReady at a clk edge.
  - Downstream transfer (pop) = oValid & iReady at a clk edge.
- States:
  - EMPTY: oValid=0, oReady=1, oCnt=0.
  - BUSY: main holds data; oValid=1, oReady=1, oCnt=1.
  - FULL: main and skid hold data; oValid=1, oReady=0, oCnt=2.
- Reset:
  - The edge with rst=1 sets state to EMPTY and loads main and skid with INI_DATA.
  - While rst=1: oReady=0 and oValid=0; iValid and iReady are ignored.
  - First cycle after rst deasserts: oReady=1, oValid=0, oCnt=0, oDat=INI_DATA.
  - Reset mid-operation discards all held data with no pop.
- Transitions (evaluated at each edge with rst=0):
  - EMPTY, push -> BUSY; main<=iDat.
  - EMPTY, no push -> EMPTY; main holds.
  - BUSY, push & pop -> BUSY; main<=iDat (back-to-back, 1 transfer/cycle).
  - BUSY, push & !pop -> FULL; skid<=iDat; main holds.
  - BUSY, !push & pop -> EMPTY; main holds its stale value; oValid=0.
  - BUSY, !push & !pop -> BUSY; hold.
  - FULL, pop -> BUSY; main<=skid. No push is possible because oReady=0; iValid/iDat are ignored.
  - FULL, !pop -> FULL; hold.
- Latency: data pushed at edge N is on oDat with oValid=1 in the cycle after edge N (1-cycle latency when not backpressured).
- Ordering: strict FIFO order; no data lost or duplicated.
- Stability: while oValid=1 and iReady=0, oDat and oValid must not change.
- oReady:
  - Never depends combinationally on iReady or iValid.
  - Deasserts in the cycle after the edge that enters FULL.
  - Reasserts in the cycle after the pop that leaves FULL.
- Data registers: load only on their enables.
  - main load enable = (push & (EMPTY | pop)) | (FULL & pop).
  - skid load enable = BUSY & push & !pop.
- Protocol violations: iValid dropping without a push is legal (the upstream is not required to hold). No X propagation from iDat when iValid=0, because no load occurs.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, WIDTH=8, INI_DATA=8'hA5 -> during rst oReady=0, oValid=0; after release oReady=1, oValid=0, oCnt=0, oDat=8'hA5.
- Streaming: iReady=1, push 8'h01..8'h10 on consecutive cycles -> oDat 8'h01..8'h10 on consecutive cycles, each 1 cycle after its push, oCnt stays 1, oReady stays 1.
- Backpressure:
  - Stimulus: push 8'h11, 8'h22, 8'h33 back-to-back with iReady=0 from the first push; iValid held with 8'h33 until accepted.
  - After the 2nd push: oCnt=2, oReady=0, oDat=8'h11 stable.
  - 8'h33 is not accepted while oReady=0.
  - Raise iReady -> sequence 8'h11, 8'h22, 8'h33 out, in order, with no gaps once ready.
- Drain: from FULL (8'h44, 8'h55), iValid=0, iReady=1 for 3 cycles -> outputs 8'h44, then 8'h55, then oValid=0; oCnt goes 2->1->0.
- Reset mid-operation: FULL with 8'h66/8'h77, assert rst for 1 cycle with iReady=1 -> no pop of either value; afterwards oValid=0, oCnt=0, oDat=INI_DATA.
- Random: 10k cycles of random iValid/iReady against a scoreboard -> order preserved, oDat stable under backpressure, oReady never a combinational function of iReady, oCnt matches pushes minus pops.
